updown_flex_counter: RTL
========================

// Module: updown_flex_counter
// PURPOSE
//  Parametrised up/down counter with programmable rollover, synchronous load,
//  and a per-cycle choice of wrap or saturate mode. It serves as the
//  general-purpose counter for byte, bit and round counting in the datapath
//  controllers. Up/wrap mode keeps the legacy flex-counter sequence:
//  0 after reset, then 1..rollover_val cyclically.
//  Adds down counting, saturation, load and a one-cycle wrap pulse.
// PARAMETERS
//  NUM_CNT_BITS   4   width of count_out, load_val and rollover_val
// PORTS
//  clk             in   1    system clock, rising edge
//  n_rst           in   1    asynchronous active-low reset
//  clear           in   1    sync clear: count -> 0
//  load            in   1    sync load: count -> load_val
//  load_val        in   N    value captured when load=1
//  count_enable    in   1    advance one step this cycle
//  dir             in   1    1 = up, 0 = down
//  sat_mode        in   1    0 = wrap at terminal, 1 = hold at terminal
//  rollover_val    in   N    upper bound R (unsigned)
//  count_out       out  N    registered count
//  rollover_flag   out  1    registered: count_out == terminal(dir)
//  rollover_pulse  out  1    registered one-cycle pulse on each wrap event
// BEHAVIOUR
//  - Reset (n_rst=0, async): count_out=0, rollover_flag=0, rollover_pulse=0.
//  - Terminal: T = R when dir=1, T = 0 when dir=0.
//  - Priority per edge: clear > load > count_enable > hold.
//  - clear: next=0, pulse=0. load: next=load_val (unclamped), pulse=0.
//  - Up, enable: count<R -> count+1; count>=R -> wrap to 1 (pulse=1)
//    if sat_mode=0, or next=R (pulse=0) if sat_mode=1.
//  - Down, enable: count>R -> next=R, pulse=0. Otherwise count>0 -> count-1.
//    count==0 -> wrap to R (pulse=1) if sat_mode=0, or hold 0 if sat_mode=1.
//  - Hold (no clear/load/enable): count unchanged, pulse=0.
//  - rollover_flag <= (next_count == T), evaluated every edge from the
//    current dir and R, including clear, load and hold cycles.
//  - rollover_pulse is high exactly one cycle, aligned with the wrapped value
//    on count_out. It is never high in sat_mode.
//  - R==0: enable holds count at 0; no pulse; flag=1 once count==0.
//  - dir, sat_mode and R may change on any cycle and take effect on the
//    next edge. No internal state other than the count and output flags.
//  - +1/-1 use N-bit arithmetic. Overflow/underflow cannot occur because
//    wrap/saturate is tested before stepping.
//  - Latency: every input affects the outputs at the following rising edge.
// TESTING
//  1. Reset, R=4, up, wrap, enable held: count 0,1,2,3,4,1,2...;
//     flag high when count=4; pulse high with each 4->1.
//  2. R=3, down, wrap, from 0: count 3,2,1,0,3; pulse on 0->3;
//     flag high when count=0.
//  3. R=5, up, sat_mode=1: count 1..5 then holds 5 with flag=1, pulse=0;
//     set dir=0: count 4,3,2,1,0, then holds 0.
//  4. Clear+load+enable all high in one cycle -> count 0. Next cycle
//     load=1, load_val=9, R=6, down, enable -> count 9, then 6 with no pulse.
//  5. n_rst asserted mid-count (count=3, pulse high) -> outputs 0 with no
//     clock edge; R=0 with enable -> count stays 0, flag=1, pulse=0.

Source files
------------

// File: rtl/updown_flex_counter_if.sv
// Control/status bundle for updown_flex_counter: the controller drives the
// step controls and bounds, and the counter returns its registered outputs.
interface updown_flex_counter_if #(
    parameter int NUM_CNT_BITS = 4
);
    logic                    clear;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic                    count_enable;
    logic                    dir;
    logic                    sat_mode;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;
    logic                    rollover_pulse;

    modport master (
        output clear, load, load_val, count_enable, dir, sat_mode, rollover_val,
        input  count_out, rollover_flag, rollover_pulse
    );

    modport slave (
        input  clear, load, load_val, count_enable, dir, sat_mode, rollover_val,
        output count_out, rollover_flag, rollover_pulse
    );
endinterface

// File: rtl/updown_flex_counter.sv
// Up/down counter with programmable rollover, sync clear/load, per-cycle
// wrap or saturate mode, a terminal-count flag and a one-cycle wrap pulse.
module updown_flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    updown_flex_counter_if.slave bus
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                    flag_q, flag_d;
    logic                    pulse_q, pulse_d;
    logic [NUM_CNT_BITS-1:0] term;
    logic [NUM_CNT_BITS-1:0] rval;

    assign rval = bus.rollover_val;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        term    = bus.dir ? rval : '0;

        if (bus.clear) begin
            cnt_d = '0;
        end else if (bus.load) begin
            cnt_d = bus.load_val;
        end else if (bus.count_enable) begin
            // A zero bound pins the count at 0 in both directions without a wrap event.
            if (rval == '0) begin
                cnt_d = '0;
            end else if (bus.dir) begin
                if (cnt_q < rval) begin
                    cnt_d = cnt_q + ONE;
                end else if (bus.sat_mode) begin
                    cnt_d = rval;
                end else begin
                    cnt_d   = ONE;
                    pulse_d = 1'b1;
                end
            end else begin
                if (cnt_q > rval) begin
                    cnt_d = rval;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (!bus.sat_mode) begin
                    cnt_d   = rval;
                    pulse_d = 1'b1;
                end
            end
        end

        flag_d = (cnt_d == term);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.count_out      = cnt_q;
    assign bus.rollover_flag  = flag_q;
    assign bus.rollover_pulse = pulse_q;
endmodule
